// File: rtl/uart_pkg.sv
// Shared UART receive-path types and constants.
package uart_pkg;

    localparam int UART_DATA_W           = 8;
    localparam int UART_ENTRY_W          = 9;
    localparam int RX_FIFO_DEPTH_DEFAULT = 16;

    // One stored frame: error flag above the data byte.
    typedef struct packed {
        logic                   err;
        logic [UART_DATA_W-1:0] data;
    } rx_entry_t;

    // Build a stored entry from a flag and a byte.
    function automatic rx_entry_t make_entry(input logic err, input logic [UART_DATA_W-1:0] data);
        rx_entry_t e;
        e.err  = err;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Storage for the receive FIFO: one write port, one registered read port.
// The array and the read register are deliberately left without reset.
import uart_pkg::*;

module uart_rx_fifo_mem #(
    parameter int DEPTH  = RX_FIFO_DEPTH_DEFAULT,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [UART_ENTRY_W-1:0] wr_data,
    input  logic                    rd_en,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic [UART_ENTRY_W-1:0] rd_data
);

    logic [UART_ENTRY_W-1:0] mem [DEPTH];

    // Write the new entry and capture the head entry; a read of the slot being
    // written in the same cycle returns the old contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver: turns frame-complete / framing-error
// levels into single write events and buffers {err, byte} entries.
import uart_pkg::*;

module uart_rx_fifo #(
    parameter int DEPTH    = RX_FIFO_DEPTH_DEFAULT,
    parameter int KEEP_ERR = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rxDone,
    input  logic                   rxErr,
    input  logic [UART_DATA_W-1:0] rxByte,
    input  logic                   rdEn,
    output logic [UART_DATA_W-1:0] rdData,
    output logic                   rdErr,
    output logic                   rdValid,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    input  logic                   clrOverflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

    logic              done_q;
    logic              err_q;
    logic              armed;
    logic              done_rise;
    logic              err_rise;
    logic              wr_req;
    logic              wr_en;
    logic              rd_en;
    logic              drop;
    logic              have_data;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [UART_ENTRY_W-1:0] mem_q;
    rx_entry_t         wr_entry;
    rx_entry_t         rd_entry;

    // Sample the receiver levels; armed stays low for the first cycle after
    // reset so a level already high at release never counts as a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            armed  <= 1'b0;
        end else begin
            done_q <= rxDone;
            err_q  <= rxErr;
            armed  <= 1'b1;
        end
    end

    // Decide the write/read actions of this cycle; any rise while rxErr is
    // high is an errored frame, which is stored only when KEEP_ERR is set.
    always_comb begin
        done_rise = armed & rxDone & ~done_q;
        err_rise  = armed & rxErr & ~err_q;
        wr_entry  = make_entry(rxErr, rxByte);
        wr_req    = (done_rise | err_rise) & (~rxErr | (KEEP_ERR != 0));
        rd_en     = rdEn & ~empty;
        wr_en     = wr_req & (~full | rd_en);
        drop      = wr_req & full & ~rd_en;
        empty     = (count == '0);
        full      = (count == FULL_COUNT);
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Read qualifier, "something has been read" flag and the sticky overflow,
    // where a new drop wins over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdValid   <= 1'b0;
            have_data <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            rdValid   <= rd_en;
            have_data <= have_data | rd_en;
            if (drop) begin
                overflow <= 1'b1;
            end else if (clrOverflow) begin
                overflow <= 1'b0;
            end
        end
    end

    uart_rx_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (mem_q)
    );

    // The memory read register has no reset, so outputs read as zero until
    // the first pop after reset; afterwards they hold the last popped entry.
    always_comb begin
        rd_entry = have_data ? rx_entry_t'(mem_q) : '0;
        rdData   = rd_entry.data;
        rdErr    = rd_entry.err;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; power of two, 4..256.
REQ-002 Parameter KEEP_ERR, default 1; 1 = store errored frames flagged, 0 = discard them.
REQ-003 Port clk input 1: the only clock; all state on its rising edge.
REQ-004 Port rst_n input 1: reset, asynchronous assert, active-low.
REQ-005 Port rxDone input 1: receiver frame-complete level; may stay high for many cycles.
REQ-006 Port rxErr input 1: receiver framing-error level; may stay high for many cycles.
REQ-007 Port rxByte input 8: receiver data byte, stable while rxDone or rxErr is high.
REQ-008 Port rdEn input 1: read request, one entry per cycle high.
REQ-009 Port rdData output 8: popped byte.
REQ-010 Port rdErr output 1: error flag of the popped entry.
REQ-011 Port rdValid output 1: one-cycle pulse qualifying rdData/rdErr.
REQ-012 Port empty output 1, full output 1: occupancy flags.
REQ-013 Port count output clog2(DEPTH)+1: entries held, 0..DEPTH.
REQ-014 Port overflow output 1: sticky, a frame was dropped because the FIFO was full.
REQ-015 Port clrOverflow input 1: synchronous clear of overflow.

Function
REQ-016 Registered rising-edge detect on rxDone and rxErr; one write event per rising edge, never per high cycle.
REQ-017 rxDone rise with rxErr low: write {err=0, rxByte} in the rise cycle.
REQ-018 rxErr rise, or both rising in one cycle: write {err=1, rxByte} if KEEP_ERR=1, else no write.
REQ-019 rxDone rise while rxErr already high: treated as error per REQ-018.
REQ-020 Write latency: count/empty/full reflect the write on the edge after the rise cycle.
REQ-021 Read: rdEn high and not empty pops the head; rdData/rdErr/rdValid registered, valid the following cycle.
REQ-022 rdEn while empty: ignored, rdValid stays 0, rdData holds its last value.
REQ-023 Write and read in one cycle, not empty: both occur, count unchanged; this includes the full case.
REQ-024 Write and read in one cycle while empty: write accepted, read ignored, count becomes 1.
REQ-025 Write while full without a read: byte dropped, contents unchanged, overflow set next edge.
REQ-026 overflow clears only via clrOverflow; a new set and clrOverflow in the same cycle leave overflow = 1.
REQ-027 Pointers clog2(DEPTH) bits, wrap modulo DEPTH; full = count==DEPTH, empty = count==0.
REQ-028 FIFO order strictly preserved across pointer wrap-around.

Reset
REQ-029 rst_n low: count=0, empty=1, full=0, overflow=0, rdValid=0, rdData=0, rdErr=0, pointers=0, edge registers=0.
REQ-030 Reset mid-operation discards all entries; no write fires for a level still high at release unless it falls and rises again.
REQ-031 Storage array is not reset.

Structure
REQ-032 Shared package uart_pkg holds UART_DATA_W=8, UART_ENTRY_W=9 ({err,data}) and RX_FIFO_DEPTH_DEFAULT=16.
REQ-033 One sub-module, uart_rx_fifo_mem: DEPTH x UART_ENTRY_W, one write port, one registered read port, no reset.

Verification
REQ-034 rxByte=0x35, rxDone high 50 cycles -> exactly one entry, count=1; rdEn pulse -> rdData=0x35, rdErr=0, rdValid for one cycle.
REQ-035 rxErr rise with rxByte=0xA5, KEEP_ERR=1 -> pop gives 0xA5, rdErr=1; repeated with KEEP_ERR=0 -> count stays 0.
REQ-036 Write 0x00..0x0F (16 frames) -> full=1; 17th frame 0x10 -> dropped, overflow=1; pops return 0x00..0x0F in order.
REQ-037 Full FIFO, rxDone rise and rdEn in one cycle -> count stays 16, head 0x00 popped, 0x10 stored last, overflow unchanged.
REQ-038 Push/pop 40 frames 0x40..0x67 with occupancy kept at 1..3 -> order preserved across wrap, no overflow.
REQ-039 rst_n low with 5 entries and rxDone held high -> count=0, empty=1 immediately; no entry after release until rxDone falls and rises.
